// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM states and the set-2 scan code to ASCII map
// for the PS/2 keyboard decoder.
package ps2_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_BKSP   = 8'h66;
   localparam logic [7:0] SC_SPACE  = 8'h29;

   localparam logic [6:0] ASC_CR = 7'd13;
   localparam logic [6:0] ASC_BS = 7'd8;
   localparam logic [6:0] ASC_SP = 7'd32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_t;

   typedef struct packed {
      logic       valid;
      logic [6:0] ascii;
   } asc_t;

   // True when the 8 data bits plus the parity bit hold an odd number of ones.
   function automatic logic odd_parity(input logic [8:0] bits);
      return ^bits;
   endfunction

   function automatic asc_t sc_to_ascii(input logic [7:0] code, input logic shift, input logic caps);
      asc_t       res;
      logic [6:0] lower;
      res.valid = 1'b1;
      res.ascii = 7'd0;
      lower     = 7'd0;
      case (code)
         8'h1C: lower = 7'h61;
         8'h32: lower = 7'h62;
         8'h21: lower = 7'h63;
         8'h23: lower = 7'h64;
         8'h24: lower = 7'h65;
         8'h2B: lower = 7'h66;
         8'h34: lower = 7'h67;
         8'h33: lower = 7'h68;
         8'h43: lower = 7'h69;
         8'h3B: lower = 7'h6A;
         8'h42: lower = 7'h6B;
         8'h4B: lower = 7'h6C;
         8'h3A: lower = 7'h6D;
         8'h31: lower = 7'h6E;
         8'h44: lower = 7'h6F;
         8'h4D: lower = 7'h70;
         8'h15: lower = 7'h71;
         8'h2D: lower = 7'h72;
         8'h1B: lower = 7'h73;
         8'h2C: lower = 7'h74;
         8'h3C: lower = 7'h75;
         8'h2A: lower = 7'h76;
         8'h1D: lower = 7'h77;
         8'h22: lower = 7'h78;
         8'h35: lower = 7'h79;
         8'h1A: lower = 7'h7A;
         // Digits and punctuation follow shift only; caps lock leaves them alone.
         8'h45: res.ascii = shift ? 7'h29 : 7'h30;
         8'h16: res.ascii = shift ? 7'h21 : 7'h31;
         8'h1E: res.ascii = shift ? 7'h40 : 7'h32;
         8'h26: res.ascii = shift ? 7'h23 : 7'h33;
         8'h25: res.ascii = shift ? 7'h24 : 7'h34;
         8'h2E: res.ascii = shift ? 7'h25 : 7'h35;
         8'h36: res.ascii = shift ? 7'h5E : 7'h36;
         8'h3D: res.ascii = shift ? 7'h26 : 7'h37;
         8'h3E: res.ascii = shift ? 7'h2A : 7'h38;
         8'h46: res.ascii = shift ? 7'h28 : 7'h39;
         8'h4E: res.ascii = shift ? 7'h5F : 7'h2D;
         8'h49: res.ascii = shift ? 7'h3E : 7'h2E;
         8'h41: res.ascii = shift ? 7'h3C : 7'h2C;
         SC_SPACE: res.ascii = ASC_SP;
         SC_ENTER: res.ascii = ASC_CR;
         SC_BKSP:  res.ascii = ASC_BS;
         default:  res.valid = 1'b0;
      endcase
      if (lower != 7'd0) begin
         res.ascii = (shift ^ caps) ? (lower - 7'h20) : lower;
      end
      return res;
   endfunction

endpackage

// File: rtl/ps2_ascii_decoder_if.sv
// Character output bus of the PS/2 decoder: decoded ASCII with its strobe,
// the frame error strobe and the modifier status lines.
interface ps2_ascii_decoder_if;
   logic [6:0] ascii;
   logic       ascii_ready;
   logic       frame_err;
   logic       shift_on;
   logic       caps_on;

   modport master (output ascii, ascii_ready, frame_err, shift_on, caps_on);
   modport slave  (input  ascii, ascii_ready, frame_err, shift_on, caps_on);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 line receiver: synchronises the raw lines, detects falling clock edges
// and assembles 11-bit frames into validated bytes, with a mid-frame timeout.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

   logic [1:0]    clk_sync_r;
   logic [1:0]    dat_sync_r;
   logic          clk_prev_r;
   frame_state_t  state_r, state_n;
   logic [2:0]    bit_cnt_r, bit_cnt_n;
   logic [7:0]    shift_r, shift_n;
   logic          parity_ok_r, parity_ok_n;
   logic [TW-1:0] to_cnt_r, to_cnt_n;
   logic [7:0]    byte_data_r;
   logic          byte_valid_r, byte_valid_n;
   logic          frame_err_r, frame_err_n;
   logic          fall_s;
   logic          bit_s;
   logic          timeout_s;

   assign fall_s    = clk_prev_r & ~clk_sync_r[1];
   assign bit_s     = dat_sync_r[1];
   assign timeout_s = (state_r != ST_IDLE) && (to_cnt_r == TO_MAX);

   // Two-flop synchronisers plus the delayed clock used for edge detection.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clk_sync_r <= 2'b11;
         dat_sync_r <= 2'b11;
         clk_prev_r <= 1'b1;
      end else begin
         clk_sync_r <= {clk_sync_r[0], ps2_clk};
         dat_sync_r <= {dat_sync_r[0], ps2_dat};
         clk_prev_r <= clk_sync_r[1];
      end
   end

   // Idle-gap counter: restarts on each edge and only runs mid-frame.
   always_comb begin
      to_cnt_n = to_cnt_r;
      if (fall_s || timeout_s || (state_r == ST_IDLE)) begin
         to_cnt_n = '0;
      end else begin
         to_cnt_n = to_cnt_r + TW'(1);
      end
   end

   // Frame FSM next state; a timeout wins over any edge seen in the same cycle.
   always_comb begin
      state_n      = state_r;
      bit_cnt_n    = bit_cnt_r;
      shift_n      = shift_r;
      parity_ok_n  = parity_ok_r;
      byte_valid_n = 1'b0;
      frame_err_n  = 1'b0;
      if (timeout_s) begin
         state_n     = ST_IDLE;
         bit_cnt_n   = 3'd0;
         shift_n     = 8'h00;
         frame_err_n = 1'b1;
      end else if (fall_s) begin
         case (state_r)
            ST_IDLE: begin
               if (!bit_s) begin
                  state_n   = ST_DATA;
                  bit_cnt_n = 3'd0;
               end else begin
                  state_n = ST_IDLE;
               end
            end
            ST_DATA: begin
               shift_n = {bit_s, shift_r[7:1]};
               if (bit_cnt_r == 3'd7) begin
                  state_n = ST_PARITY;
               end else begin
                  bit_cnt_n = bit_cnt_r + 3'd1;
               end
            end
            ST_PARITY: begin
               parity_ok_n = odd_parity({bit_s, shift_r});
               state_n     = ST_STOP;
            end
            ST_STOP: begin
               if (bit_s && parity_ok_r) begin
                  byte_valid_n = 1'b1;
               end else begin
                  frame_err_n = 1'b1;
               end
               state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end else begin
         state_n = state_r;
      end
   end

   // Frame state, shift register and registered byte/error strobes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r      <= ST_IDLE;
         bit_cnt_r    <= 3'd0;
         shift_r      <= 8'h00;
         parity_ok_r  <= 1'b0;
         to_cnt_r     <= '0;
         byte_data_r  <= 8'h00;
         byte_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         state_r      <= state_n;
         bit_cnt_r    <= bit_cnt_n;
         shift_r      <= shift_n;
         parity_ok_r  <= parity_ok_n;
         to_cnt_r     <= to_cnt_n;
         byte_data_r  <= byte_valid_n ? shift_r : byte_data_r;
         byte_valid_r <= byte_valid_n;
         frame_err_r  <= frame_err_n;
      end
   end

   assign byte_data  = byte_data_r;
   assign byte_valid = byte_valid_r;
   assign frame_err  = frame_err_r;

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 keyboard to ASCII: tracks break/extended prefixes and modifier keys and
// emits one registered ASCII strobe per mapped key make.
module ps2_ascii_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ps2_clk,
   input  logic                       ps2_dat,
   ps2_ascii_decoder_if.master        key_bus
);

   logic [7:0] byte_data_s;
   logic       byte_valid_s;
   logic       frame_err_s;
   asc_t       map_s;

   logic       brk_r, brk_n;
   logic       ext_r, ext_n;
   logic       shl_r, shl_n;
   logic       shr_r, shr_n;
   logic       caps_r, caps_n;
   logic       caps_held_r, caps_held_n;
   logic [6:0] ascii_r, ascii_n;
   logic       ascii_ready_r, ascii_ready_n;

   ps2_rx_frame #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk        (clk),
      .resetn     (resetn),
      .ps2_clk    (ps2_clk),
      .ps2_dat    (ps2_dat),
      .byte_data  (byte_data_s),
      .byte_valid (byte_valid_s),
      .frame_err  (frame_err_s)
   );

   assign map_s = sc_to_ascii(byte_data_s, shl_r | shr_r, caps_r);

   // Decode layer: prefixes latch, any other byte consumes and clears them.
   always_comb begin
      brk_n         = brk_r;
      ext_n         = ext_r;
      shl_n         = shl_r;
      shr_n         = shr_r;
      caps_n        = caps_r;
      caps_held_n   = caps_held_r;
      ascii_n       = ascii_r;
      ascii_ready_n = 1'b0;
      if (byte_valid_s) begin
         if (byte_data_s == SC_BREAK) begin
            brk_n = 1'b1;
         end else if (byte_data_s == SC_EXT) begin
            ext_n = 1'b1;
         end else begin
            brk_n = 1'b0;
            ext_n = 1'b0;
            if (!ext_r) begin
               case (byte_data_s)
                  SC_LSHIFT: shl_n = ~brk_r;
                  SC_RSHIFT: shr_n = ~brk_r;
                  SC_CAPS: begin
                     // Caps toggles once per physical press, not per typematic repeat.
                     if (brk_r) begin
                        caps_held_n = 1'b0;
                     end else if (!caps_held_r) begin
                        caps_n      = ~caps_r;
                        caps_held_n = 1'b1;
                     end else begin
                        caps_held_n = caps_held_r;
                     end
                  end
                  default: begin
                     if (!brk_r && map_s.valid) begin
                        ascii_n       = map_s.ascii;
                        ascii_ready_n = 1'b1;
                     end else begin
                        ascii_ready_n = 1'b0;
                     end
                  end
               endcase
            end else begin
               ascii_ready_n = 1'b0;
            end
         end
      end else begin
         ascii_ready_n = 1'b0;
      end
   end

   // Decode flags and registered character outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         brk_r         <= 1'b0;
         ext_r         <= 1'b0;
         shl_r         <= 1'b0;
         shr_r         <= 1'b0;
         caps_r        <= 1'b0;
         caps_held_r   <= 1'b0;
         ascii_r       <= 7'd0;
         ascii_ready_r <= 1'b0;
      end else begin
         brk_r         <= brk_n;
         ext_r         <= ext_n;
         shl_r         <= shl_n;
         shr_r         <= shr_n;
         caps_r        <= caps_n;
         caps_held_r   <= caps_held_n;
         ascii_r       <= ascii_n;
         ascii_ready_r <= ascii_ready_n;
      end
   end

   assign key_bus.ascii       = ascii_r;
   assign key_bus.ascii_ready = ascii_ready_r;
   assign key_bus.frame_err   = frame_err_s;
   assign key_bus.shift_on    = shl_r | shr_r;
   assign key_bus.caps_on     = caps_r;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Scoreboard bench for ps2_ascii_decoder: frames are bit-banged on the PS/2
// lines, expected characters queued, and strobes checked as they appear.
module tb_ps2_ascii_decoder;

   localparam int unsigned TO   = 200;
   localparam int          HALF = 10;

   localparam logic [7:0] LET [26] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
      8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
      8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   localparam logic [7:0] SYM_CODE [16] = '{
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
      8'h29, 8'h5A, 8'h66, 8'h4E, 8'h49, 8'h41};
   localparam logic [6:0] SYM_LO [16] = '{
      "0", "1", "2", "3", "4", "5", "6", "7", "8", "9",
      7'd32, 7'd13, 7'd8, "-", ".", ","};
   localparam logic [6:0] SYM_HI [16] = '{
      ")", "!", "@", "#", "$", "%", "^", "&", "*", "(",
      7'd32, 7'd13, 7'd8, "_", ">", "<"};

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_dat = 1'b1;

   int checks     = 0;
   int errors     = 0;
   int cyc        = 0;
   int stop_cyc   = 0;
   int err_pulses = 0;
   logic [6:0] exp_q [$];
   logic [6:0] exp_v;

   ps2_ascii_decoder_if bus ();

   ps2_ascii_decoder #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .ps2_clk (ps2_clk),
      .ps2_dat (ps2_dat),
      .key_bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every strobe must match the queue head, 4 cycles after the stop edge.
   always @(negedge clk) begin
      if (bus.frame_err) err_pulses++;
      if (bus.ascii_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe ascii=%h expected no strobe", bus.ascii);
         end else begin
            exp_v = exp_q.pop_front();
            if (bus.ascii !== exp_v) begin
               errors++;
               $display("FAIL ascii got=%h exp=%h", bus.ascii, exp_v);
            end
            checks++;
            if (cyc != stop_cyc + 4) begin
               errors++;
               $display("FAIL strobe_latency got=%0d exp=%0d", cyc - stop_cyc, 4);
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] code, input bit flip_par, input bit bad_stop, input int nbits);
      logic [10:0] bits;
      bits = {~bad_stop, (~^code) ^ flip_par, code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = bits[i];
         repeat (HALF) @(posedge clk);
         #1;
         ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         repeat (HALF) @(posedge clk);
         #1;
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
      repeat (2 * HALF) @(posedge clk);
      #1;
   endtask

   task automatic key(input logic [7:0] code);
      send_frame(code, 1'b0, 1'b0, 11);
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.ascii, bus.ascii_ready, bus.frame_err, bus.shift_on, bus.caps_on} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {bus.ascii, bus.ascii_ready, bus.frame_err, bus.shift_on, bus.caps_on});
      end
      resetn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_basic;
      exp_q.push_back(7'h61);
      key(8'h1C);
      exp_q.push_back(7'h61);
      key(8'h1C);
      key(8'hF0);
      key(8'h1C);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_missing got=%0d pending exp=0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_shift;
      key(8'h12);
      checks++;
      if (bus.shift_on !== 1'b1) begin
         errors++;
         $display("FAIL shift_on_make got=%b exp=1", bus.shift_on);
      end
      exp_q.push_back(7'h41);
      key(8'h1C);
      key(8'hF0);
      key(8'h12);
      checks++;
      if (bus.shift_on !== 1'b0) begin
         errors++;
         $display("FAIL shift_on_break got=%b exp=0", bus.shift_on);
      end
      exp_q.push_back(7'h61);
      key(8'h1C);
      key(8'h59);
      exp_q.push_back(7'h5A);
      key(8'h1A);
      key(8'hF0);
      key(8'h59);
      exp_q.push_back(7'h7A);
      key(8'h1A);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL shift_missing got=%0d pending exp=0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_caps;
      key(8'h58);
      checks++;
      if (bus.caps_on !== 1'b1) begin
         errors++;
         $display("FAIL caps_on_toggle got=%b exp=1", bus.caps_on);
      end
      key(8'hF0);
      key(8'h58);
      exp_q.push_back(7'h41);
      key(8'h1C);
      key(8'h58);
      key(8'h58);
      key(8'hF0);
      key(8'h58);
      exp_q.push_back(7'h61);
      key(8'h1C);
      checks++;
      if (bus.caps_on !== 1'b0) begin
         errors++;
         $display("FAIL caps_on_end got=%b exp=0", bus.caps_on);
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL caps_missing got=%0d pending exp=0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_letters;
      int sh;
      for (int i = 0; i < 26; i++) begin
         sh = $urandom_range(0, 1);
         if (sh != 0) key(8'h12);
         exp_q.push_back((sh != 0) ? 7'(65 + i) : 7'(97 + i));
         key(LET[i]);
         if (sh != 0) begin
            key(8'hF0);
            key(8'h12);
         end
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL letters_missing got=%0d pending exp=0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_symbols;
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(SYM_LO[i]);
         key(SYM_CODE[i]);
      end
      key(8'h12);
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(SYM_HI[i]);
         key(SYM_CODE[i]);
      end
      key(8'hF0);
      key(8'h12);
      key(8'h58);
      key(8'hF0);
      key(8'h58);
      exp_q.push_back(7'h33);
      key(8'h26);
      key(8'h58);
      key(8'hF0);
      key(8'h58);
      key(8'h76);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL symbols_missing got=%0d pending exp=0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_ext;
      key(8'hE0);
      key(8'h12);
      checks++;
      if (bus.shift_on !== 1'b0) begin
         errors++;
         $display("FAIL ext_shift got=%b exp=0", bus.shift_on);
      end
      key(8'hE0);
      key(8'h1C);
      key(8'hE0);
      key(8'hF0);
      key(8'h1C);
      exp_q.push_back(7'h61);
      key(8'h1C);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL ext_missing got=%0d pending exp=0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_bad_frames;
      int e0;
      e0 = err_pulses;
      send_frame(8'h1C, 1'b1, 1'b0, 11);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (err_pulses != e0 + 1) begin
         errors++;
         $display("FAIL parity_err got=%0d pulses exp=1", err_pulses - e0);
      end
      checks++;
      if (bus.ascii !== 7'h61) begin
         errors++;
         $display("FAIL parity_hold got=%h exp=61", bus.ascii);
      end
      e0 = err_pulses;
      send_frame(8'h32, 1'b0, 1'b1, 11);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (err_pulses != e0 + 1) begin
         errors++;
         $display("FAIL stop_err got=%0d pulses exp=1", err_pulses - e0);
      end
   endtask

   task automatic test_timeout;
      int e0;
      e0 = err_pulses;
      send_frame(8'h1C, 1'b0, 1'b0, 6);
      repeat (TO + 10) @(posedge clk);
      #1;
      checks++;
      if (err_pulses != e0 + 1) begin
         errors++;
         $display("FAIL timeout_err got=%0d pulses exp=1", err_pulses - e0);
      end
      exp_q.push_back(7'd8);
      key(8'h66);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL timeout_recover got=%0d pending exp=0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset_midframe;
      send_frame(8'h5A, 1'b0, 1'b0, 4);
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.ascii, bus.ascii_ready, bus.frame_err, bus.shift_on, bus.caps_on} !== 11'd0) begin
         errors++;
         $display("FAIL midreset_outputs got=%h exp=0",
                  {bus.ascii, bus.ascii_ready, bus.frame_err, bus.shift_on, bus.caps_on});
      end
      resetn = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      exp_q.push_back(7'd13);
      key(8'h5A);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0 || bus.ascii !== 7'd13) begin
         errors++;
         $display("FAIL midreset_decode got=%h pending=%0d exp=0d", bus.ascii, exp_q.size());
      end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_shift();
      test_caps();
      test_letters();
      test_symbols();
      test_ext();
      test_bad_frames();
      test_timeout();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_ascii_decoder.md
# ps2_ascii_decoder

Receives PS/2 keyboard frames, decodes set-2 scan codes and produces one ASCII code per key press with a single-cycle strobe. It sits directly upstream of the search/edit modes and drives their `asciiin`/`asciiready` inputs. Consumers apply their own rate limiting. This block does no debounce beyond frame validation.

## Interface
- `TIMEOUT_CYCLES`, default 50000: idle `clk` cycles without a PS/2 falling edge, mid-frame, before the frame is abandoned (1 ms at 50 MHz).
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `resetn` input, 1 bit: reset, asynchronous and active-low.
- `ps2_clk` input, 1 bit: raw keyboard clock, asynchronous.
- `ps2_dat` input, 1 bit: raw keyboard data, asynchronous.
- `ascii` output, 7 bits: last decoded character; holds its value between strobes.
- `ascii_ready` output, 1 bit: one-cycle strobe; `ascii` is valid in the same cycle.
- `frame_err` output, 1 bit: one-cycle strobe on a parity error, a bad stop bit or a timeout.
- `shift_on`, `caps_on` outputs, 1 bit each: current modifier state, for LED/debug.

## Operation
- **Input sync:** `ps2_clk` and `ps2_dat` each pass through 2 flops. A falling edge is "synced clk was 1 last cycle and is 0 now". Data is sampled on that edge.
- **Frame FSM:** states IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: an edge with data=0 (start bit) goes to DATA with bitcnt=0. An edge with data=1 is ignored.
  - DATA: shift bits in LSB first. After bitcnt reaches 7, go to PARITY.
  - PARITY: require odd parity over the 8 data bits plus the parity bit.
  - STOP: require data=1. On success, emit the byte to the decode layer. On failure, pulse `frame_err` and discard the byte. Either way, return to IDLE.
- **Timeout:** a counter clears on every edge and counts up in any non-IDLE state. When it reaches `TIMEOUT_CYCLES`, force IDLE, pulse `frame_err` and discard partial data.
- **Decode layer:** flags `brk`, `ext`, `shl`, `shr`, `caps`, `caps_held`.
  - 0xF0 sets `brk`. 0xE0 sets `ext`. Neither produces output.
  - Any other byte is consumed together with the current flags, then `brk` and `ext` clear.
  - With `ext` set, the byte changes no modifier and emits nothing.
  - 0x12 updates `shl` and 0x59 updates `shr`: set on make, clear on break.
  - 0x58 on make with `caps_held`=0 toggles `caps` and sets `caps_held`. 0x58 on break clears `caps_held`.
  - A break of any other key emits nothing.
  - A make of a mapped key emits its character. Typematic repeats emit again.
- **Map:** `shift` = `shl`|`shr`.
  - Letters 0x1C..0x1A (set-2 codes): lowercase when `shift`^`caps`=0, uppercase otherwise.
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 give '0'..'9'. With `shift` they give `)!@#$%^&*(`. Caps has no effect on digits.
  - 0x29 gives 32 (space). 0x5A gives 13 (enter). 0x66 gives 8 (backspace).
  - 0x4E gives '-'/'_'. 0x49 gives '.'/'>'. 0x41 gives ','/'<'.
  - Any other byte emits nothing.
- **Reset values:** `ascii`=0, `ascii_ready`=0, `frame_err`=0, all flags 0, FSM in IDLE, timeout counter 0, sync flops 1.

## Timing
- Stop-bit edge detected in cycle E → byte register valid at E+1 → `ascii`/`ascii_ready` (or flag update) at E+2.
- `frame_err` is asserted at E+1 for stop/parity errors, or in the cycle after the timeout count is reached.
- At most one strobe per frame. PS/2 frames are ≥0.6 ms apart, so decode never back-pressures and there is no handshake.
- Reset asserted mid-frame aborts the frame immediately. No strobe fires. The first clean frame after release decodes normally.
- A start bit arriving in the same cycle a timeout fires is ignored. The keyboard retransmits.

## Structure
- **Package `ps2_pkg`:** scan-code constants (`SC_BREAK`=0xF0, `SC_EXT`=0xE0, `SC_LSHIFT`, `SC_RSHIFT`, `SC_CAPS`, `SC_ENTER`, `SC_BKSP`, `SC_SPACE`), ASCII constants (`ASC_CR`=13, `ASC_BS`=8, `ASC_SP`=32), frame FSM state enum, and a pure function `sc_to_ascii(code, shift, caps)` that returns {valid, ascii}.
- **Sub-module `ps2_rx_frame`:** sync, edge detect, frame FSM and timeout. Outputs `byte_data[7:0]`, `byte_valid`, `frame_err`.
- The top module holds the decode flags, the output register and `shift_on`/`caps_on`.

## Test plan
- Frame 0x1C (valid parity) → `ascii`=0x61, `ascii_ready` high exactly 1 cycle at E+2. Then F0,1C → no strobe.
- Frames 12, 1C, F0 12, 1C → strobes 0x41 then 0x61. `shift_on` 1 then 0.
- Frames 58, F0 58, 1C, 58, 58, F0 58, 1C → 0x41, then 0x61 (second 58 is ignored while held). `caps_on` ends 0.
- Frame 0x1C with the parity bit flipped → `frame_err` pulse, no `ascii_ready`, `ascii` keeps its previous value.
- Stop after 5 data bits, wait `TIMEOUT_CYCLES`+2 → single `frame_err`. Then frame 0x66 → `ascii`=8.
- Drop `resetn` after 4 bits of frame 0x5A, release, send 0x5A → no early strobe, then `ascii`=13. Outputs are 0 during reset.
